// File: rtl/score_bcd_converter_if.sv
// Handshake bundle for the score binary-to-BCD converter.
// master drives start/bin_in, slave returns busy/done/bcd_out/ovf.
interface score_bcd_converter_if #(
    parameter int IN_W   = 11,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [IN_W-1:0]       bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ovf
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ovf
    );
endinterface

// File: rtl/score_bcd_converter.sv
// Iterative shift-add-3 binary-to-BCD converter for the score display.
// One input bit per clock; result held in registers between conversions.
module score_bcd_converter #(
    parameter int IN_W   = 11,
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    score_bcd_converter_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam int TW = BW + IN_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          r_state;
    logic [IN_W-1:0] r_shift;
    logic [BW-1:0]   r_bcd;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_ovf;
    logic [BW-1:0]   r_bcd_out;

    logic [BW-1:0]   w_adj;
    logic [TW-1:0]   w_cat;
    logic            w_out;
    logic [BW-1:0]   w_bcd_nxt;
    logic [IN_W-1:0] w_shift_nxt;

    // Add 3 to every digit >=5 so the following doubling carries correctly
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_cat = {w_adj, r_shift};
    assign w_out = w_cat[TW-1];
    assign {w_bcd_nxt, w_shift_nxt} = {w_cat[TW-2:0], 1'b0};

    // Control FSM with working registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bcd     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_bcd_out <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_shift <= bus.bin_in;
                        r_bcd   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= CW'(IN_W);
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift <= w_shift_nxt;
                    r_bcd   <= w_bcd_nxt;
                    r_carry <= r_carry | w_out;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_bcd_out <= w_bcd_nxt;
                        r_ovf     <= r_carry | w_out;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.bcd_out = r_bcd_out;
    assign bus.ovf     = r_ovf;
endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed plus randomized bench for score_bcd_converter.
// Runs a 4-digit and a 3-digit instance side by side on the same stimulus.
module tb_score_bcd_converter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    score_bcd_converter_if #(.IN_W(11), .DIGITS(4)) b4 ();
    score_bcd_converter_if #(.IN_W(11), .DIGITS(3)) b3 ();

    score_bcd_converter #(.IN_W(11), .DIGITS(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    score_bcd_converter #(.IN_W(11), .DIGITS(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by divide/modulo, packed four bits per digit
    function automatic logic [31:0] ref_bcd(input int v, input int nd);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r = r | (32'((v / p) % 10) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    task automatic drive(input logic s, input int v);
        b4.start  = s;
        b3.start  = s;
        b4.bin_in = 11'(v);
        b3.bin_in = 11'(v);
    endtask

    // Full conversion on both instances with latency/busy/done checks
    task automatic conv(input int v);
        int lat;
        int nbusy;
        int ndone;
        bit got;
        @(negedge clk);
        drive(1'b1, v);
        @(posedge clk);
        #1;
        chk("busy_after_accept", 32'(b4.busy), 32'd1);
        @(negedge clk);
        drive(1'b0, (v + 333) % 2048);
        lat = 0;
        nbusy = 1;
        ndone = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (b4.busy) nbusy++;
            if (b4.done) begin
                got = 1;
                ndone++;
            end
        end
        chk("latency", 32'(lat), 32'd11);
        chk("done3_aligned", 32'(b3.done), 32'd1);
        chk("bcd4", 32'(b4.bcd_out), ref_bcd(v, 4));
        chk("ovf4", 32'(b4.ovf), 32'(v >= pow10(4)));
        chk("bcd3", 32'(b3.bcd_out), ref_bcd(v, 3));
        chk("ovf3", 32'(b3.ovf), 32'(v >= pow10(3)));
        @(posedge clk);
        #1;
        chk("done_single", 32'(b4.done), 32'd0);
        chk("busy_fall", 32'(b4.busy), 32'd0);
        chk("busy_cycles", 32'(nbusy), 32'd12);
        chk("bcd4_hold", 32'(b4.bcd_out), ref_bcd(v, 4));
    endtask

    int perm[2048];
    int tmp;
    int j;
    int nd;
    int sampled;

    initial begin
        drive(1'b0, 0);
        #12;
        chk("rst_busy", 32'(b4.busy), 32'd0);
        chk("rst_done", 32'(b4.done), 32'd0);
        chk("rst_bcd", 32'(b4.bcd_out), 32'd0);
        chk("rst_ovf", 32'(b4.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        conv(0);
        conv(2047);
        conv(1234);
        conv(10);
        conv(999);
        conv(1000);

        // start held high, bin_in changed mid-conversion
        @(negedge clk);
        drive(1'b1, 5);
        @(posedge clk);
        #1;
        drive(1'b1, 7);
        nd = 0;
        sampled = 0;
        while (b4.busy && sampled < 40) begin
            @(posedge clk);
            #1;
            sampled++;
            if (b4.done) begin
                nd++;
                chk("hold_bcd", 32'(b4.bcd_out), 32'h0005);
            end
        end
        chk("hold_one_done", 32'(nd), 32'd1);
        chk("hold_busy_fell", 32'(b4.busy), 32'd0);
        @(posedge clk);
        #1;
        chk("hold_restart", 32'(b4.busy), 32'd1);
        @(negedge clk);
        drive(1'b0, 0);
        sampled = 0;
        while (!b4.done && sampled < 40) begin
            @(posedge clk);
            #1;
            sampled++;
        end
        chk("hold_second_bcd", 32'(b4.bcd_out), 32'h0007);
        @(posedge clk);
        #1;

        // reset mid-conversion
        @(negedge clk);
        drive(1'b1, 1500);
        @(posedge clk);
        #1;
        drive(1'b0, 0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(b4.busy), 32'd0);
        chk("mid_rst_done", 32'(b4.done), 32'd0);
        chk("mid_rst_bcd", 32'(b4.bcd_out), 32'd0);
        chk("mid_rst_ovf", 32'(b4.ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (b4.done || b4.busy) nd++;
        end
        chk("no_done_after_rst", 32'(nd), 32'd0);
        conv(42);

        // every input once, random order
        for (int i = 0; i < 2048; i++) perm[i] = i;
        for (int i = 2047; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 2048; i++) conv(perm[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
